// File: rtl/sdram_req_ctrl.sv
// Per-channel toggle req/ack front-end with a one-deep pending slot and an ack-paced clear sequencer.
// Latency: one cycle from event to mem_req toggle; backpressure: events while outstanding park in the slot, latest wins.
module sdram_req_ctrl #(
    parameter int               NCH       = 6,
    parameter int               AW        = 23,
    parameter int               DW        = 16,
    parameter logic [NCH-1:0]   ADDR_TRIG = 6'b110111,
    parameter logic [NCH-1:0]   CLR_MASK  = 6'b110000,
    parameter logic [AW-1:0]    CLR_LAST  = 23'h007FFF
) (
    input  logic                clk_sys,
    input  logic                n_reset,
    input  logic [NCH-1:0]      ch_ce,
    input  logic [NCH-1:0]      ch_rd,
    input  logic [NCH-1:0]      ch_wr,
    input  logic [NCH*AW-1:0]   ch_addr,
    input  logic [NCH*DW-1:0]   ch_din,
    input  logic [NCH-1:0]      mem_ack,
    output logic [NCH-1:0]      mem_req,
    output logic [NCH*AW-1:0]   mem_addr,
    output logic [NCH-1:0]      mem_we,
    output logic [NCH*DW-1:0]   mem_din,
    input  logic                clr_start,
    output logic                clr_busy,
    output logic [NCH-1:0]      ch_busy,
    output logic [NCH-1:0]      ch_ovf
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ISSUE, S_WAIT} clr_state_t;

    clr_state_t          state_q, state_d;
    logic [AW-1:0]       clr_addr_q, clr_addr_d;
    logic [NCH-1:0]      req_q, req_d, we_q, we_d;
    logic [NCH*AW-1:0]   addr_q, addr_d, addr_last_q, addr_last_d;
    logic [NCH*DW-1:0]   din_q, din_d;
    logic [NCH-1:0]      rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
    logic [NCH-1:0]      pend_vld_q, pend_vld_d, pend_we_q, pend_we_d;
    logic [NCH*AW-1:0]   pend_addr_q, pend_addr_d;
    logic [NCH*DW-1:0]   pend_din_q, pend_din_d;
    logic [NCH-1:0]      ovf_q, ovf_d;

    logic [NCH-1:0]      rd, wr, outst, ev;
    logic                clr_idle;

    assign rd       = ch_ce & ch_rd;
    assign wr       = ch_ce & ch_wr;
    assign outst    = req_q ^ mem_ack;
    assign clr_idle = &(~outst | ~CLR_MASK);
    assign clr_busy = (state_q != S_IDLE);

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign mem_we   = we_q;
    assign mem_din  = din_q;
    assign ch_busy  = outst | pend_vld_q;
    assign ch_ovf   = ovf_q;

    always_comb begin
        ev = '0;
        for (int i = 0; i < NCH; i++) begin
            ev[i] = (rd[i] & ~rd_prev_q[i]) | (wr[i] & ~wr_prev_q[i]) |
                    (ADDR_TRIG[i] & rd[i] & (ch_addr[i*AW +: AW] != addr_last_q[i*AW +: AW]));
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        addr_last_d = addr_last_q;
        pend_vld_d  = pend_vld_q;
        pend_we_d   = pend_we_q;
        pend_addr_d = pend_addr_q;
        pend_din_d  = pend_din_q;
        ovf_d       = ovf_q;
        rd_prev_d   = rd;
        wr_prev_d   = wr;

        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d    = S_DRAIN;
                    clr_addr_d = '0;
                end
            end
            S_DRAIN: if (clr_idle) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (clr_idle) begin
                    if (clr_addr_q == CLR_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < NCH; i++) begin
            if (CLR_MASK[i] && clr_busy) begin
                // Sequencer owns the channel: strobes are ignored, addr_last is frozen.
                if (state_q == S_DRAIN) pend_vld_d[i] = 1'b0;
                if (state_q == S_ISSUE) begin
                    req_d[i]              = ~req_q[i];
                    addr_d[i*AW +: AW]    = clr_addr_q;
                    we_d[i]               = 1'b1;
                    din_d[i*DW +: DW]     = '0;
                end
            end else begin
                if (ev[i]) addr_last_d[i*AW +: AW] = ch_addr[i*AW +: AW];
                if (!outst[i] && pend_vld_q[i]) begin
                    // Slot drains first; a same-cycle event refills it behind the drained entry.
                    req_d[i]              = ~req_q[i];
                    addr_d[i*AW +: AW]    = pend_addr_q[i*AW +: AW];
                    we_d[i]               = pend_we_q[i];
                    din_d[i*DW +: DW]     = pend_din_q[i*DW +: DW];
                    pend_vld_d[i]         = ev[i];
                    if (ev[i]) begin
                        pend_addr_d[i*AW +: AW] = ch_addr[i*AW +: AW];
                        pend_we_d[i]            = wr[i];
                        pend_din_d[i*DW +: DW]  = ch_din[i*DW +: DW];
                    end
                end else if (!outst[i] && ev[i]) begin
                    req_d[i]              = ~req_q[i];
                    addr_d[i*AW +: AW]    = ch_addr[i*AW +: AW];
                    we_d[i]               = wr[i];
                    din_d[i*DW +: DW]     = ch_din[i*DW +: DW];
                end else if (ev[i]) begin
                    if (pend_vld_q[i] && pend_we_q[i]) ovf_d[i] = 1'b1;
                    pend_vld_d[i]           = 1'b1;
                    pend_addr_d[i*AW +: AW] = ch_addr[i*AW +: AW];
                    pend_we_d[i]            = wr[i];
                    pend_din_d[i*DW +: DW]  = ch_din[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= S_IDLE;
            clr_addr_q  <= '0;
            req_q       <= '0;
            we_q        <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            addr_last_q <= '1;
            pend_vld_q  <= '0;
            pend_we_q   <= '0;
            pend_addr_q <= '0;
            pend_din_q  <= '0;
            ovf_q       <= '0;
            rd_prev_q   <= '0;
            wr_prev_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            addr_last_q <= addr_last_d;
            pend_vld_q  <= pend_vld_d;
            pend_we_q   <= pend_we_d;
            pend_addr_q <= pend_addr_d;
            pend_din_q  <= pend_din_d;
            ovf_q       <= ovf_d;
            rd_prev_q   <= rd_prev_d;
            wr_prev_q   <= wr_prev_d;
        end
    end

endmodule

// File: tb/tb_sdram_req_ctrl.sv
// Directed vector table for single-channel traffic plus hand-written clear and reset-abort sequences.
module tb_sdram_req_ctrl;
    localparam int NCH = 6;
    localparam int AW  = 23;
    localparam int DW  = 16;

    logic                clk_sys = 1'b0;
    logic                n_reset;
    logic [NCH-1:0]      ch_ce, ch_rd, ch_wr, mem_ack, mem_req, mem_we, ch_busy, ch_ovf;
    logic [NCH*AW-1:0]   ch_addr, mem_addr;
    logic [NCH*DW-1:0]   ch_din, mem_din;
    logic                clr_start, clr_busy;

    int checks = 0;
    int failures = 0;

    logic [NCH-1:0] auto_en;
    int ack_dly [NCH];
    int ack_cnt [NCH];

    sdram_req_ctrl #(
        .NCH(NCH), .AW(AW), .DW(DW),
        .ADDR_TRIG(6'b110011), .CLR_MASK(6'b110000), .CLR_LAST(23'd3)
    ) dut (
        .clk_sys(clk_sys), .n_reset(n_reset),
        .ch_ce(ch_ce), .ch_rd(ch_rd), .ch_wr(ch_wr),
        .ch_addr(ch_addr), .ch_din(ch_din),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_din(mem_din),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ch_busy(ch_busy), .ch_ovf(ch_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int ch; logic ce, rd, wr; logic [AW-1:0] addr; logic [DW-1:0] din; logic ack;
        logic req; logic [AW-1:0] eaddr; logic we; logic [DW-1:0] edin; logic busy, ovf;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(int c, int ce, int rd, int wr, int a, int d, int ack,
                                int req, int ea, int we, int ed, int busy, int ovf);
        vec_t v;
        v.ch = c; v.ce = ce[0]; v.rd = rd[0]; v.wr = wr[0];
        v.addr = AW'(a); v.din = DW'(d); v.ack = ack[0];
        v.req = req[0]; v.eaddr = AW'(ea); v.we = we[0]; v.edin = DW'(ed);
        v.busy = busy[0]; v.ovf = ovf[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock, then the sdram model acks any channel it owns after ack_dly cycles.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (auto_en[i] && (mem_req[i] != mem_ack[i])) begin
                ack_dly[i]++;
                if (ack_dly[i] >= 2) begin
                    mem_ack[i] = ~mem_ack[i];
                    ack_dly[i] = 0;
                    ack_cnt[i]++;
                end
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) begin
            ack_dly[i] = 0;
            ack_cnt[i] = 0;
        end
    endtask

    initial begin
        logic prev4, prev5;
        int   tog;
        bit   done;

        n_reset = 1'b0; ch_ce = '0; ch_rd = '0; ch_wr = '0; ch_addr = '0; ch_din = '0;
        mem_ack = '0; clr_start = 1'b0; auto_en = '0;
        clear_model();

        tbl[0]  = mk(0,1,1,0,'h1234,0,0,    1,'h1234,0,0,1,0);
        tbl[1]  = mk(0,1,1,0,'h1234,0,1,    1,'h1234,0,0,0,0);
        tbl[2]  = mk(0,1,1,0,'h10,0,1,      0,'h10,0,0,1,0);
        tbl[3]  = mk(0,1,1,0,'h11,0,1,      0,'h10,0,0,1,0);
        tbl[4]  = mk(0,1,1,0,'h11,0,1,      0,'h10,0,0,1,0);
        tbl[5]  = mk(0,1,1,0,'h11,0,1,      0,'h10,0,0,1,0);
        tbl[6]  = mk(0,1,1,0,'h11,0,1,      0,'h10,0,0,1,0);
        tbl[7]  = mk(0,1,1,0,'h11,0,0,      1,'h11,0,0,1,0);
        tbl[8]  = mk(0,0,0,0,'h11,0,1,      1,'h11,0,0,0,0);
        tbl[9]  = mk(2,1,1,0,'h50,0,0,      1,'h50,0,0,1,0);
        tbl[10] = mk(2,1,1,0,'h51,0,1,      1,'h50,0,0,0,0);
        tbl[11] = mk(2,0,0,0,'h51,0,1,      1,'h50,0,0,0,0);
        tbl[12] = mk(2,1,0,1,'h60,'h11,1,   0,'h60,1,'h11,1,0);
        tbl[13] = mk(2,1,0,0,'h60,'h11,1,   0,'h60,1,'h11,1,0);
        tbl[14] = mk(2,1,0,1,'h61,'hAA,1,   0,'h60,1,'h11,1,0);
        tbl[15] = mk(2,1,0,0,'h61,'hAA,1,   0,'h60,1,'h11,1,0);
        tbl[16] = mk(2,1,0,1,'h62,'hBB,1,   0,'h60,1,'h11,1,1);
        tbl[17] = mk(2,1,0,0,'h62,'hBB,0,   1,'h62,1,'hBB,1,1);
        tbl[18] = mk(2,0,0,0,'h62,'hBB,1,   1,'h62,1,'hBB,0,1);
        tbl[19] = mk(1,1,1,0,'h100,0,0,     1,'h100,0,0,1,0);
        tbl[20] = mk(1,1,1,0,'h101,0,0,     1,'h100,0,0,1,0);
        tbl[21] = mk(1,1,1,0,'h102,0,1,     0,'h101,0,0,1,0);
        tbl[22] = mk(1,1,1,0,'h102,0,1,     0,'h101,0,0,1,0);
        tbl[23] = mk(1,1,1,0,'h102,0,0,     1,'h102,0,0,1,0);
        tbl[24] = mk(1,0,0,0,'h102,0,1,     1,'h102,0,0,0,0);

        #12;
        chk("rst_req", 64'(mem_req), 0);
        chk("rst_addr", 64'(mem_addr != '0), 0);
        chk("rst_we_din", 64'({mem_we, mem_din != '0}), 0);
        chk("rst_busy", 64'({clr_busy, ch_busy, ch_ovf}), 0);
        #10 n_reset = 1'b1;
        @(posedge clk_sys); #1;

        for (int r = 0; r < 25; r++) begin
            int c;
            c = tbl[r].ch;
            ch_ce = '0; ch_rd = '0; ch_wr = '0;
            ch_ce[c] = tbl[r].ce; ch_rd[c] = tbl[r].rd; ch_wr[c] = tbl[r].wr;
            ch_addr[c*AW +: AW] = tbl[r].addr;
            ch_din[c*DW +: DW]  = tbl[r].din;
            mem_ack[c] = tbl[r].ack;
            tick();
            chk($sformatf("row%0d", r),
                {mem_req[c], 23'(mem_addr[c*AW +: AW]), mem_we[c], 16'(mem_din[c*DW +: DW]), ch_busy[c], ch_ovf[c]},
                {tbl[r].req, tbl[r].eaddr, tbl[r].we, tbl[r].edin, tbl[r].busy, tbl[r].ovf});
        end

        // Clear sequence with concurrent channel 0 traffic and discarded channel 4 strobes.
        ch_ce = '0; ch_rd = '0; ch_wr = '0;
        auto_en = 6'b110001;
        clear_model();
        prev4 = mem_req[4]; prev5 = mem_req[5];
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        chk("clr_busy_set", 64'(clr_busy), 1);
        tog = 0; done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (k == 3) begin ch_ce[0] = 1'b1; ch_rd[0] = 1'b1; ch_addr[0 +: AW] = 23'h200; end
            if (k == 5) begin
                ch_ce[4] = 1'b1; ch_wr[4] = 1'b1;
                ch_addr[4*AW +: AW] = 23'h7777; ch_din[4*DW +: DW] = 16'h5555;
            end
            if (k == 7) begin ch_ce[4] = 1'b0; ch_wr[4] = 1'b0; end
            tick();
            if (k == 3) chk("ch0_during_clr", {mem_req[0], 23'(mem_addr[0 +: AW])}, {1'b0, 23'h200});
            if (mem_req[4] != prev4) begin
                chk($sformatf("clr_tog%0d", tog),
                    {23'(mem_addr[4*AW +: AW]), mem_we[4], 16'(mem_din[4*DW +: DW]),
                     mem_req[5] != prev5, 23'(mem_addr[5*AW +: AW]), mem_we[5]},
                    {23'(tog), 1'b1, 16'h0, 1'b1, 23'(tog), 1'b1});
                tog++;
            end
            prev4 = mem_req[4]; prev5 = mem_req[5];
            if (!clr_busy) begin
                done = 1;
                chk("clr_count", {32'(tog), 32'(ack_cnt[4])}, {32'd4, 32'd4});
                chk("clr_done_idle", 64'(ch_busy[5:4]), 0);
            end
        end
        if (!done) chk("clr_timeout", 1, 0);
        ch_ce = '0; ch_rd = '0;

        // Reset abort while waiting on the ack for address 2, then restart.
        clear_model();
        prev4 = mem_req[4];
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        tog = 0; done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            tick();
            if (mem_req[4] != prev4) tog++;
            prev4 = mem_req[4];
            if (tog == 3) done = 1;
        end
        if (!done) chk("abort_timeout", 1, 0);
        chk("abort_addr2", 64'(mem_addr[4*AW +: AW]), 2);
        n_reset = 1'b0; mem_ack = '0; clear_model();
        #1;
        chk("abort_req", 64'(mem_req), 0);
        chk("abort_addr", 64'(mem_addr != '0), 0);
        chk("abort_we_din", 64'({mem_we, mem_din != '0}), 0);
        chk("abort_busy_ovf", 64'({clr_busy, ch_busy, ch_ovf}), 0);
        tick();
        n_reset = 1'b1;
        prev4 = mem_req[4];
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        tog = 0; done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            tick();
            if (mem_req[4] != prev4) begin
                if (tog == 0) chk("restart_addr0", 64'(mem_addr[4*AW +: AW]), 0);
                tog++;
            end
            prev4 = mem_req[4];
            if (!clr_busy) done = 1;
        end
        if (!done) chk("restart_timeout", 1, 0);
        chk("restart_count", 64'(tog), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_req_ctrl.md
Name: sdram_req_ctrl

Overview:
- Parametrised request front-end between the SNES core's memory strobes (ROM, WRAM, BSRAM, ARAM, VRAM1/2) and the multi-port sdram controller.
- Turns each channel's CE/RD/WR/address activity into toggle-style req/ack transactions.
- Adds a one-deep pending slot per channel, so events raised while a transfer is outstanding are not lost.
- Contains a memory-clear sequencer that zero-fills selected channels after reset, paced by acks rather than a fixed divider.

Parameters:
- NCH, 6: number of channels.
- AW, 23: address width per channel.
- DW, 16: data width per channel.
- ADDR_TRIG, 6'b110111: bit i set means an address change during a read issues a new request on channel i.
- CLR_MASK, 6'b110000: channels written by the clear sequencer.
- CLR_LAST, 23'h007FFF: last address written by the clear sequencer.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- ch_ce  in  NCH  channel chip enable, active high.
- ch_rd  in  NCH  channel read strobe, active high.
- ch_wr  in  NCH  channel write strobe, active high.
- ch_addr  in  NCH*AW  channel addresses; channel i at [i*AW +: AW].
- ch_din  in  NCH*DW  channel write data.
- mem_ack  in  NCH  sdram ack toggles.
- mem_req  out  NCH  request toggles.
- mem_addr  out  NCH*AW  registered request address.
- mem_we  out  NCH  registered write flag.
- mem_din  out  NCH*DW  registered write data.
- clr_start  in  1  pulse; starts the clear sequence.
- clr_busy  out  1  clear sequence in progress.
- ch_busy  out  NCH  request outstanding (mem_req != mem_ack) or pending slot valid.
- ch_ovf  out  NCH  sticky; a pending write was overwritten.

Behaviour:
- Reset (async, n_reset=0):
  - mem_req, mem_we, mem_addr, mem_din, clr_busy, ch_ovf = 0; pending slots empty.
  - rd_d, wr_d = 0; addr_last = all ones; clear FSM in IDLE; clr_addr = 0.
- Qualified strobes: rd = ce & ch_rd; wr = ce & ch_wr.
- Event on channel i in cycle t when any of these hold:
  - rd rising edge (rd & ~rd_d);
  - wr rising edge (wr & ~wr_d);
  - ADDR_TRIG[i] & rd & (ch_addr != addr_last).
- Event type is write if wr=1, otherwise read. rd_d and wr_d register every cycle.
- addr_last captures ch_addr on every accepted event.
- Issue when idle (mem_req==mem_ack, pending empty):
  - At edge t+1, mem_req toggles; mem_addr, mem_we, mem_din load the event values.
  - Latency is one cycle.
- Outstanding (mem_req!=mem_ack):
  - The event is stored in the pending slot (addr, we, din).
  - A later event overwrites the slot, latest wins. If the overwritten entry was a write, ch_ovf[i] is set.
- Drain: the cycle mem_ack==mem_req with the slot valid, the slot issues at the next edge and empties.
  - A simultaneous new event in that cycle goes into the slot after the drain, so order is preserved.
- Events on different channels are fully independent; no cross-channel arbitration.
- Clear FSM, clear channels = channels with CLR_MASK set:
  - IDLE: on clr_start go to DRAIN, set clr_busy=1, clr_addr=0. clr_start while busy is ignored.
  - DRAIN: clear pending slots on the clear channels; wait until all of them have ack==req, then go to ISSUE.
  - ISSUE: toggle mem_req on all clear channels with mem_addr=clr_addr, mem_we=1, mem_din=0, then go to WAIT.
  - WAIT: when all clear channels have ack==req:
    - if clr_addr==CLR_LAST, go to IDLE and set clr_busy=0 on the same edge;
    - otherwise increment clr_addr and go to ISSUE.
- While clr_busy, channel events on the clear channels are discarded: no pending capture, addr_last unchanged. Other channels operate normally.
- clr_addr is AW bits wide. CLR_LAST must not exceed 2^AW-1; no wrap is permitted.
- Asserting n_reset low mid-operation aborts any clear or transfer immediately. The sdram side must reset its ack toggles on the same reset.

Test Plan:
- Idle channel 0, rd rise with addr 0x001234 -> next edge mem_req[0]=1, mem_addr=0x001234, mem_we=0; ack toggled -> ch_busy[0]=0.
- Channel 0 read held, addr steps 0x10→0x11 with ack delayed 5 cycles -> second request is pending, issues exactly 1 cycle after ack matches, mem_addr=0x11.
- Channel 2 (ADDR_TRIG=0) read held, addr changes -> no new request.
- Two writes while outstanding (D=0xAA then 0xBB) -> a single pending write of 0xBB is issued; ch_ovf[2]=1.
- clr_start with CLR_LAST=3 and the sdram model acking after 2 cycles -> four write toggles on channels 4 and 5 with addr 0..3 and data 0; clr_busy drops after the 4th ack; channel 0 traffic is unaffected throughout.
- n_reset pulsed low during WAIT at addr 2 -> all outputs return to reset values; a subsequent clr_start restarts from addr 0.
